// File: rtl/tinytout_pkg.sv
// tinytout_pkg: shared widths and writeback source encoding for the integer core.
package tinytout_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/regfile_writeback_unit_if.sv
// regfile_writeback_unit_if: result handshakes, issue hazard query and register-file write port.
interface regfile_writeback_unit_if
  import tinytout_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
);
  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADDR_W-1:0]    alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [ADDR_W-1:0]    lsu_rd;
  logic [DATA_W-1:0]    lsu_data;
  logic                 iss_valid;
  logic [ADDR_W-1:0]    iss_rs1;
  logic [ADDR_W-1:0]    iss_rs2;
  logic                 iss_rs1_used;
  logic                 iss_rs2_used;
  logic [ADDR_W-1:0]    iss_rd;
  logic                 iss_stall;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [2**ADDR_W-1:0] busy_mask;
  logic [CNT_W-1:0]     wb_count;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rs1, iss_rs2, iss_rs1_used, iss_rs2_used, iss_rd,
    input  alu_ready, lsu_ready, iss_stall, rf_we, rf_waddr, rf_wdata, busy_mask, wb_count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rs1, iss_rs2, iss_rs1_used, iss_rs2_used, iss_rd,
    output alu_ready, lsu_ready, iss_stall, rf_we, rf_waddr, rf_wdata, busy_mask, wb_count
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register busy bits reserved at issue, released on writeback; drives the issue stall.
module wb_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_iss_valid,
  input  logic [ADDR_W-1:0]    i_rs1,
  input  logic [ADDR_W-1:0]    i_rs2,
  input  logic                 i_rs1_used,
  input  logic                 i_rs2_used,
  input  logic [ADDR_W-1:0]    i_iss_rd,
  input  logic                 i_clr_en,
  input  logic [ADDR_W-1:0]    i_clr_rd,
  output logic                 o_stall,
  output logic [2**ADDR_W-1:0] o_busy
);
  localparam int N = 2**ADDR_W;
  localparam logic [N-1:0] ONE = N'(1);
  logic [N-1:0] r_busy;
  logic [N-1:0] w_set;
  logic [N-1:0] w_clr;
  logic         w_set_en;
  always_comb begin
    o_stall  = i_iss_valid & ((i_rs1_used & r_busy[i_rs1]) | (i_rs2_used & r_busy[i_rs2]) | r_busy[i_iss_rd]);
    w_set_en = i_iss_valid & !o_stall & (i_iss_rd != '0);
    w_set    = w_set_en ? ONE << i_iss_rd : '0;
    w_clr    = i_clr_en ? ONE << i_clr_rd : '0;
  end
  // Set is OR-ed after the clear so a same-cycle reservation survives the release.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_busy <= '0;
    else     r_busy <= w_set | (r_busy & ~w_clr);
  assign o_busy = r_busy;
  // A write must target a reserved register (or one being reserved this very cycle).
  a_write_reserved: assert property (@(posedge clk) disable iff (rst)
    i_clr_en |-> (r_busy[i_clr_rd] || w_set[i_clr_rd]))
    else $error("writeback to unreserved register x%0d", i_clr_rd);
endmodule

// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit: LSU-over-ALU arbitration onto the register-file write port,
// registered write stage, saturating commit counter and RAW/WAW scoreboard.
module regfile_writeback_unit
  import tinytout_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  regfile_writeback_unit_if.slave bus
);
  wb_src_e           w_src;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;
  logic              w_wr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  assign bus.lsu_ready = 1'b1;
  assign bus.alu_ready = !bus.lsu_valid;
  always_comb begin
    w_src  = bus.lsu_valid ? WB_LSU : (bus.alu_valid ? WB_ALU : WB_NONE);
    w_rd   = (w_src == WB_LSU) ? bus.lsu_rd : bus.alu_rd;
    w_data = (w_src == WB_LSU) ? bus.lsu_data : bus.alu_data;
    w_wr   = (w_src != WB_NONE) && (w_rd != '0);
  end
  // Address/data hold their last value when nothing is written (x0 results are swallowed).
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
      if (w_wr && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_iss_valid  (bus.iss_valid),
    .i_rs1        (bus.iss_rs1),
    .i_rs2        (bus.iss_rs2),
    .i_rs1_used   (bus.iss_rs1_used),
    .i_rs2_used   (bus.iss_rs2_used),
    .i_iss_rd     (bus.iss_rd),
    .i_clr_en     (w_wr),
    .i_clr_rd     (w_rd),
    .o_stall      (bus.iss_stall),
    .o_busy       (bus.busy_mask)
  );
  assign bus.rf_we    = r_we;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;
  assign bus.wb_count = r_cnt;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb_regfile_writeback_unit: directed scenarios for arbitration, write stage, scoreboard and counter.
module tb_regfile_writeback_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  regfile_writeback_unit_if bus();
  regfile_writeback_unit_if #(.CNT_W(2)) sbus();
  regfile_writeback_unit dut (.clk(clk), .rst(rst), .bus(bus));
  regfile_writeback_unit #(.CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(sbus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rd);
    bus.iss_valid = v; bus.iss_rs1 = rs1; bus.iss_rs1_used = u1; bus.iss_rd = rd;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic sat_drive(input logic v);
    sbus.iss_valid = v; sbus.iss_rd = 5'd1; sbus.lsu_valid = v; sbus.lsu_rd = 5'd1; sbus.lsu_data = 32'h5;
  endtask

  task automatic test_reset;
    issue(0, 0, 0, 0); alu(0, 0, 0); lsu(0, 0, 0);
    bus.iss_rs2 = '0; bus.iss_rs2_used = 1'b0;
    sbus.alu_valid = 0; sbus.alu_rd = '0; sbus.alu_data = '0; sbus.iss_rs1 = '0; sbus.iss_rs2 = '0;
    sbus.iss_rs1_used = 0; sbus.iss_rs2_used = 0; sat_drive(0);
    #2;
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h want 0", bus.rf_we); end
    n_chk++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0h want 0", bus.rf_waddr); end
    n_chk++; if (bus.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.rf_wdata); end
    n_chk++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
    n_chk++; if (bus.wb_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.wb_count); end
    n_chk++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lsu_ready: got %0h want 1", bus.lsu_ready); end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_alu_only;
    issue(1, 0, 0, 5); #1;
    n_chk++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL alu_resv_stall: got %0h want 0", bus.iss_stall); end
    tick;
    n_chk++; if (bus.busy_mask !== 32'h20) begin n_fail++; $display("FAIL alu_resv_busy: got %h want 00000020", bus.busy_mask); end
    issue(0, 0, 0, 0); alu(1, 5, 32'hDEADBEEF); #1;
    n_chk++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %0h want 1", bus.alu_ready); end
    tick;
    n_chk++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %0h want 1", bus.rf_we); end
    n_chk++; if (bus.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_waddr: got %0d want 5", bus.rf_waddr); end
    n_chk++; if (bus.rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata: got %h want deadbeef", bus.rf_wdata); end
    n_chk++; if (bus.wb_count !== 16'd1) begin n_fail++; $display("FAIL alu_count: got %0d want 1", bus.wb_count); end
    n_chk++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL alu_release: got %h want 0", bus.busy_mask); end
    alu(0, 0, 0);
    tick;
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop: got %0h want 0", bus.rf_we); end
    n_chk++; if (bus.rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wdata_hold: got %h want deadbeef", bus.rf_wdata); end
  endtask

  task automatic test_conflict;
    issue(1, 0, 0, 3); tick;
    issue(1, 0, 0, 4); tick;
    issue(0, 0, 0, 0);
    n_chk++; if (bus.busy_mask !== 32'h18) begin n_fail++; $display("FAIL cf_busy: got %h want 00000018", bus.busy_mask); end
    lsu(1, 3, 32'h11); alu(1, 4, 32'h22); #1;
    n_chk++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL cf_alu_ready: got %0h want 0", bus.alu_ready); end
    n_chk++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL cf_lsu_ready: got %0h want 1", bus.lsu_ready); end
    tick;
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3) begin n_fail++; $display("FAIL cf_lsu_write: got we=%0h addr=%0d want we=1 addr=3", bus.rf_we, bus.rf_waddr); end
    n_chk++; if (bus.rf_wdata !== 32'h11) begin n_fail++; $display("FAIL cf_lsu_data: got %h want 00000011", bus.rf_wdata); end
    n_chk++; if (bus.busy_mask !== 32'h10) begin n_fail++; $display("FAIL cf_busy_mid: got %h want 00000010", bus.busy_mask); end
    lsu(0, 0, 0); #1;
    n_chk++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL cf_alu_ready2: got %0h want 1", bus.alu_ready); end
    tick;
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4) begin n_fail++; $display("FAIL cf_alu_write: got we=%0h addr=%0d want we=1 addr=4", bus.rf_we, bus.rf_waddr); end
    n_chk++; if (bus.rf_wdata !== 32'h22) begin n_fail++; $display("FAIL cf_alu_data: got %h want 00000022", bus.rf_wdata); end
    n_chk++; if (bus.wb_count !== 16'd3) begin n_fail++; $display("FAIL cf_count: got %0d want 3", bus.wb_count); end
    n_chk++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL cf_busy_end: got %h want 0", bus.busy_mask); end
    alu(0, 0, 0);
  endtask

  task automatic test_raw;
    issue(1, 0, 0, 7); tick;
    n_chk++; if (bus.busy_mask !== 32'h80) begin n_fail++; $display("FAIL raw_resv: got %h want 00000080", bus.busy_mask); end
    issue(1, 7, 1, 8); #1;
    n_chk++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall0: got %0h want 1", bus.iss_stall); end
    tick;
    n_chk++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall1: got %0h want 1", bus.iss_stall); end
    n_chk++; if (bus.busy_mask !== 32'h80) begin n_fail++; $display("FAIL raw_no_resv: got %h want 00000080", bus.busy_mask); end
    lsu(1, 7, 32'h77); #1;
    n_chk++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_release_cycle: got %0h want 1", bus.iss_stall); end
    tick;
    lsu(0, 0, 0);
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL raw_write: got we=%0h addr=%0d want we=1 addr=7", bus.rf_we, bus.rf_waddr); end
    #1;
    n_chk++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL raw_unstall: got %0h want 0", bus.iss_stall); end
    tick;
    issue(0, 0, 0, 0);
    n_chk++; if (bus.busy_mask !== 32'h100) begin n_fail++; $display("FAIL raw_issue_rd8: got %h want 00000100", bus.busy_mask); end
  endtask

  task automatic test_set_clear;
    issue(1, 0, 0, 9); alu(1, 9, 32'h99); #1;
    n_chk++; if (bus.iss_stall !== 1'b0 || bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL sc_handshake: got stall=%0h ready=%0h want stall=0 ready=1", bus.iss_stall, bus.alu_ready); end
    tick;
    issue(0, 0, 0, 0); alu(0, 0, 0);
    n_chk++; if (bus.busy_mask !== 32'h300) begin n_fail++; $display("FAIL sc_busy: got %h want 00000300", bus.busy_mask); end
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h99) begin n_fail++; $display("FAIL sc_write: got we=%0h addr=%0d data=%h want 1/9/00000099", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_chk++; if (bus.wb_count !== 16'd5) begin n_fail++; $display("FAIL sc_count: got %0d want 5", bus.wb_count); end
  endtask

  task automatic test_x0;
    alu(1, 0, 32'hFFFFFFFF); #1;
    n_chk++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0h want 1", bus.alu_ready); end
    tick;
    alu(0, 0, 0);
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0h want 0", bus.rf_we); end
    n_chk++; if (bus.wb_count !== 16'd5) begin n_fail++; $display("FAIL x0_count: got %0d want 5", bus.wb_count); end
    n_chk++; if (bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h99) begin n_fail++; $display("FAIL x0_hold: got addr=%0d data=%h want 9/00000099", bus.rf_waddr, bus.rf_wdata); end
    issue(1, 0, 0, 0); #1;
    n_chk++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %0h want 0", bus.iss_stall); end
    tick;
    issue(0, 0, 0, 0);
    n_chk++; if (bus.busy_mask !== 32'h300) begin n_fail++; $display("FAIL x0_busy: got %h want 00000300", bus.busy_mask); end
  endtask

  task automatic test_saturate;
    sat_drive(1);
    tick;
    n_chk++; if (sbus.wb_count !== 2'd1) begin n_fail++; $display("FAIL sat_count1: got %0d want 1", sbus.wb_count); end
    tick; tick;
    n_chk++; if (sbus.wb_count !== 2'd3) begin n_fail++; $display("FAIL sat_count3: got %0d want 3", sbus.wb_count); end
    tick; tick;
    n_chk++; if (sbus.wb_count !== 2'd3 || sbus.rf_we !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got count=%0d we=%0h want 3/1", sbus.wb_count, sbus.rf_we); end
    sat_drive(0);
    tick;
  endtask

  task automatic test_reset_mid_write;
    issue(1, 0, 0, 10); tick;
    issue(0, 0, 0, 0); lsu(1, 10, 32'hAA); tick;
    lsu(0, 0, 0);
    n_chk++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.wb_count !== 16'd6) begin n_fail++; $display("FAIL rst_pre: got we=%0h addr=%0d count=%0d want 1/10/6", bus.rf_we, bus.rf_waddr, bus.wb_count); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_async_we: got %0h want 0", bus.rf_we); end
    n_chk++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL rst_async_busy: got %h want 0", bus.busy_mask); end
    n_chk++; if (bus.wb_count !== 16'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", bus.wb_count); end
    n_chk++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_async_addr_data: got %0d/%h want 0/0", bus.rf_waddr, bus.rf_wdata); end
    n_chk++; if (sbus.wb_count !== 2'd0) begin n_fail++; $display("FAIL rst_async_sat: got %0d want 0", sbus.wb_count); end
    #2 rst = 1'b0;
    tick;
    n_chk++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL rst_after: got we=%0h busy=%h want 0/0", bus.rf_we, bus.busy_mask); end
  endtask

  initial begin
    test_reset;
    test_alu_only;
    test_conflict;
    test_raw;
    test_set_clear;
    test_x0;
    test_saturate;
    test_reset_mid_write;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
